// File: rtl/planning_controller.sv
// planning_controller: waypoint-following robot controller for the grid planning plant, holding while an obstacle blocks the next cell.
// Optional `PLANNING_STALL_TIMEOUT_EN adds a blocked-tick counter that freezes the controller after WAITMAX blocked ticks.
module planning_controller #(
  parameter int K       = 2,
  parameter int TX      = 5,
  parameter int TY      = 5,
  parameter int WAITMAX = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       end_init,
  input  logic       move_robot,
  input  logic [3:0] obs1_x,
  input  logic [3:0] obs1_y,
  input  logic [3:0] obs2_x,
  input  logic [3:0] obs2_y,
  output logic       controllable_up,
  output logic       controllable_down,
  output logic       controllable_left,
  output logic       controllable_right,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [2:0] phase,
  output logic       done,
  output logic       stalled
);
  localparam logic [3:0] Y_HI = 4'(2*K);
  localparam logic [3:0] X_HI = 4'(2*K-1);
  localparam logic [3:0] Y_LO = 4'(2*K-1);
  localparam logic [3:0] X_T  = 4'(TX);
  localparam logic [3:0] Y_T  = 4'(TY);
  typedef enum logic [2:0] {IDLE, UP, EAST_HI, DROP, EAST_LO, CLIMB, DONE} phase_t;
  phase_t st, st_n;
  logic init_q, step, frozen, adv, done_n, stall_n;
  logic [3:0] cmd, cmd_n, want_n, x_n, y_n;
  // Direction vector {up,down,left,right} toward the phase waypoint; zero once it is reached.
  function automatic logic [3:0] want(input phase_t p, input logic [3:0] x, input logic [3:0] y);
    return (p == UP      && y != Y_HI) ? 4'b1000 :
           (p == EAST_HI && x != X_HI) ? 4'b0001 :
           (p == DROP    && y != Y_LO) ? 4'b0100 :
           (p == EAST_LO && x != X_T ) ? 4'b0001 :
           (p == CLIMB   && y != Y_T ) ? 4'b1000 : 4'b0000;
  endfunction
  function automatic logic hits(input logic [3:0] c, input logic [3:0] x, input logic [3:0] y,
                                input logic [3:0] ax, input logic [3:0] ay,
                                input logic [3:0] bx, input logic [3:0] by);
    logic [3:0] nx, ny;
    nx = x + {3'b0, c[0]} - {3'b0, c[1]};
    ny = y + {3'b0, c[3]} - {3'b0, c[2]};
    return (|c) && ((nx == ax && ny == ay) || (nx == bx && ny == by));
  endfunction
  // Commands are computed from the post-edge position so back-to-back ticks never overshoot a waypoint.
  always_comb begin
    step   = init_q & move_robot & (|cmd);
    x_n    = step ? pos_x + {3'b0, cmd[0]} - {3'b0, cmd[1]} : pos_x;
    y_n    = step ? pos_y + {3'b0, cmd[3]} - {3'b0, cmd[2]} : pos_y;
    frozen = done | stalled;
    adv    = (st == IDLE) ? init_q : (st != DONE && want(st, pos_x, pos_y) == 4'b0);
    st_n   = (adv && !frozen) ? phase_t'(st + 3'd1) : st;
    done_n = done | (pos_x == X_T && pos_y == Y_T);
    want_n = want(st_n, x_n, y_n);
    cmd_n  = (done_n || stall_n || hits(want_n, x_n, y_n, obs1_x, obs1_y, obs2_x, obs2_y)) ? 4'b0 : want_n;
  end
`ifdef PLANNING_STALL_TIMEOUT_EN
  logic [2:0] wait_cnt, wait_n;
  logic blk_now;
  always_comb begin
    blk_now = hits(want(st, pos_x, pos_y), pos_x, pos_y, obs1_x, obs1_y, obs2_x, obs2_y);
    wait_n  = step ? 3'd0 :
              (init_q && move_robot && blk_now && !frozen && wait_cnt != 3'(WAITMAX)) ? wait_cnt + 3'd1 : wait_cnt;
    stall_n = stalled | (wait_n == 3'(WAITMAX));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wait_cnt <= 3'd0;
      stalled  <= 1'b0;
    end else begin
      wait_cnt <= wait_n;
      stalled  <= stall_n;
    end
`else
  assign stall_n = 1'b0;
  assign stalled = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init_q <= 1'b0;
      st     <= IDLE;
      cmd    <= 4'b0;
      pos_x  <= 4'd0;
      pos_y  <= 4'd0;
      done   <= 1'b0;
    end else begin
      init_q <= init_q | end_init;
      st     <= st_n;
      cmd    <= cmd_n;
      pos_x  <= x_n;
      pos_y  <= y_n;
      done   <= done_n;
    end
  assign phase = st;
  assign {controllable_up, controllable_down, controllable_left, controllable_right} = cmd;
endmodule
